// File: rtl/sha512_rd_fetch.sv
// ============================================================================
// Module  : sha512_rd_fetch
// Purpose : Issues CCI-P line reads, reorders responses by mdata slot and
//           streams the lines in address order to the SHA-512 core.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sha512_rd_fetch #(
  parameter int ROB_DEPTH = 16,
  parameter int ADDR_W    = 42,
  parameter int MDATA_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        ctl,
  input  logic [ADDR_W-1:0]  addr_base,
  input  logic [31:0]        num_lines,
  input  logic               c0_tx_almfull,
  output logic               rd_req_valid,
  output logic [ADDR_W-1:0]  rd_req_addr,
  output logic [MDATA_W-1:0] rd_req_mdata,
  input  logic               rd_rsp_valid,
  input  logic [MDATA_W-1:0] rd_rsp_mdata,
  input  logic [511:0]       rd_rsp_data,
  output logic               blk_valid,
  output logic [511:0]       blk_data,
  output logic               blk_last,
  input  logic               blk_ready,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               err_unexp
);

  localparam int IDX_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           r_state;
  logic                 r_start_q;
  logic [ADDR_W-1:0]    r_base;
  logic [31:0]          r_num;
  logic [31:0]          r_issued;
  logic [31:0]          r_received;
  logic [31:0]          r_retired;
  logic [ROB_DEPTH-1:0] r_vld;
  logic [ROB_DEPTH-1:0] r_out;
  logic [511:0]         r_mem [ROB_DEPTH];
  logic                 r_err;
  logic                 r_aborted;
  logic                 r_req_valid;
  logic [ADDR_W-1:0]    r_req_addr;
  logic [IDX_W-1:0]     r_req_slot;

  logic [IDX_W-1:0]     w_head;
  logic [IDX_W-1:0]     w_rsp_slot;
  logic [IDX_W-1:0]     w_issue_slot;
  logic                 w_start;
  logic                 w_issue;
  logic                 w_rsp_active;
  logic                 w_rsp_ok;
  logic                 w_blk_valid;
  logic                 w_pop;
  logic [31:0]          w_retired_nxt;
  logic [ROB_DEPTH-1:0] w_vld_nxt;
  logic [ROB_DEPTH-1:0] w_out_nxt;
  logic                 w_unused_bits;

  assign w_head        = r_retired[IDX_W-1:0];
  assign w_issue_slot  = r_issued[IDX_W-1:0];
  assign w_rsp_slot    = rd_rsp_mdata[IDX_W-1:0];
  assign w_start       = ctl[0] & ~r_start_q;
  assign w_issue       = (r_state == S_RUN) && !ctl[1] && (r_issued < r_num) &&
                         !c0_tx_almfull && ((r_issued - r_retired) < 32'(ROB_DEPTH));
  assign w_rsp_active  = rd_rsp_valid && ((r_state == S_RUN) || (r_state == S_DRAIN));
  // A slot accepts exactly one response per issued request.
  assign w_rsp_ok      = r_out[w_rsp_slot] && !r_vld[w_rsp_slot];
  assign w_blk_valid   = (r_state == S_RUN) && r_vld[w_head];
  assign w_pop         = w_blk_valid && blk_ready;
  assign w_retired_nxt = r_retired + 32'd1;
  assign w_unused_bits = ^{ctl[31:2], rd_rsp_mdata[MDATA_W-1:IDX_W]};

  // While draining, a matching response only releases its slot; data is discarded.
  always_comb begin
    w_vld_nxt = r_vld;
    w_out_nxt = r_out;
    if ((r_state == S_IDLE) && w_start) begin
      w_vld_nxt = '0;
      w_out_nxt = '0;
    end
    if (w_issue) w_out_nxt[w_issue_slot] = 1'b1;
    if (w_rsp_active && w_rsp_ok) begin
      if (r_state == S_RUN) w_vld_nxt[w_rsp_slot] = 1'b1;
      else                  w_out_nxt[w_rsp_slot] = 1'b0;
    end
    if (w_pop) begin
      w_vld_nxt[w_head] = 1'b0;
      w_out_nxt[w_head] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_start_q   <= 1'b0;
      r_base      <= '0;
      r_num       <= '0;
      r_issued    <= '0;
      r_received  <= '0;
      r_retired   <= '0;
      r_vld       <= '0;
      r_out       <= '0;
      r_err       <= 1'b0;
      r_aborted   <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_slot  <= '0;
    end else begin
      r_start_q   <= ctl[0];
      r_req_valid <= w_issue;
      r_vld       <= w_vld_nxt;
      r_out       <= w_out_nxt;
      if (w_issue) begin
        r_req_addr <= r_base + ADDR_W'(r_issued);
        r_req_slot <= w_issue_slot;
        r_issued   <= r_issued + 32'd1;
      end
      if (w_rsp_active) begin
        if (w_rsp_ok) r_received <= r_received + 32'd1;
        else          r_err      <= 1'b1;
      end
      if (w_pop) r_retired <= w_retired_nxt;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_base     <= addr_base;
          r_num      <= num_lines;
          r_issued   <= '0;
          r_received <= '0;
          r_retired  <= '0;
          r_err      <= 1'b0;
          r_aborted  <= 1'b0;
          r_state    <= (num_lines == 32'd0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (ctl[1])                                   r_state <= S_DRAIN;
          else if (w_pop && (w_retired_nxt == r_num))   r_state <= S_DONE;
        end
        S_DRAIN: if (r_received == r_issued) begin
          r_state   <= S_DONE;
          r_aborted <= 1'b1;
        end
        S_DONE: if (!ctl[0]) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rsp_active && w_rsp_ok && (r_state == S_RUN)) r_mem[w_rsp_slot] <= rd_rsp_data;
  end

  assign rd_req_valid = r_req_valid;
  assign rd_req_addr  = r_req_addr;
  assign rd_req_mdata = MDATA_W'(r_req_slot);
  assign blk_valid    = w_blk_valid;
  assign blk_data     = w_blk_valid ? r_mem[w_head] : '0;
  assign blk_last     = w_blk_valid && (r_retired == (r_num - 32'd1));
  assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done         = (r_state == S_DONE);
  assign aborted      = r_aborted;
  assign err_unexp    = r_err;

endmodule

`default_nettype wire
